// File: rtl/stream_buf_in_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_buf_in_if
//  Description : Output bundle of the input-stream source buffer. The source
//                drives the stream word through the master modport and
//                downstream stages read it through the slave modport.
//  Signals     : data_out [DATA_WIDTH-1:0]  current stream word
//  Revision    : 1.0  initial release
// ============================================================================
interface stream_buf_in_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output data_out);
    modport slave  (input  data_out);
endinterface
`default_nettype wire

// File: rtl/stream_buf_in.sv
`default_nettype none
// ============================================================================
//  Module      : stream_buf_in
//  Description : Self-contained input-stream source for the LDPC datapath.
//                Holds a fixed table of 2**ADDR_WIDTH words, where word i
//                is (i + 1) mod 2**DATA_WIDTH. It streams the table out one
//                registered word per clock, in address order, and wraps
//                forever. There is no load port and no handshake.
//  Ports       : clk       system clock, rising edge
//                rst       asynchronous reset, active low
//                o_stream  master modport carrying data_out[DATA_WIDTH-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module stream_buf_in #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  wire              clk,
    input  wire              rst,
    stream_buf_in_if.master  o_stream
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Constant table. It is built from elaboration-time constants only, so
    // reset never touches its contents.
    logic [DATA_WIDTH-1:0] w_mem [c_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_mem
            // Truncation to DATA_WIDTH bits gives the modulo wrap of values
            // when the table is deeper than the value range.
            localparam logic [DATA_WIDTH-1:0] c_VAL = DATA_WIDTH'(gi + 1);
            assign w_mem[gi] = c_VAL;
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_word = w_mem[r_rd_addr];

    // The pointer wraps naturally at ADDR_WIDTH bits, so the stream goes
    // straight from the last entry back to entry 0 with no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_addr  <= '0;
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rd_word;
            r_rd_addr  <= r_rd_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_stream.data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_stream_buf_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_buf_in
//  Description : Self-checking bench for stream_buf_in. Three instances run
//                side by side: default (4,2), (8,3) and (2,3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_buf_in;

    logic clk;
    logic rst;

    stream_buf_in_if #(.DATA_WIDTH(4)) if_a ();
    stream_buf_in_if #(.DATA_WIDTH(8)) if_b ();
    stream_buf_in_if #(.DATA_WIDTH(2)) if_c ();

    stream_buf_in #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .o_stream (if_a)
    );
    stream_buf_in #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .o_stream (if_b)
    );
    stream_buf_in #(.DATA_WIDTH(2), .ADDR_WIDTH(3)) dut_c (
        .clk      (clk),
        .rst      (rst),
        .o_stream (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input int ea, input int eb, input int ec);
        check({tag, " a"}, 32'(if_a.data_out), 32'(ea));
        check({tag, " b"}, 32'(if_b.data_out), 32'(eb));
        check({tag, " c"}, 32'(if_c.data_out), 32'(ec));
    endtask

    task automatic check_ptrs_zero(input string tag);
        check({tag, " ptr a"}, 32'(dut_a.r_rd_addr), 32'd0);
        check({tag, " ptr b"}, 32'(dut_b.r_rd_addr), 32'd0);
        check({tag, " ptr c"}, 32'(dut_c.r_rd_addr), 32'd0);
    endtask

    // Drive rst between edges, take one edge, sample 1 time unit later.
    task automatic step(input logic r, input int ea, input int eb, input int ec, input string tag);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        #1;
        check_all(tag, ea, eb, ec);
    endtask

    typedef struct {
        logic rst;
        int   exp_a;
        int   exp_b;
        int   exp_c;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Reset hold, then the first 8 edges of the stream.
        vecs[0]  = '{1'b0, 0, 0, 0};
        vecs[1]  = '{1'b0, 0, 0, 0};
        vecs[2]  = '{1'b0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1, 1, 1};
        vecs[4]  = '{1'b1, 2, 2, 2};
        vecs[5]  = '{1'b1, 3, 3, 3};
        vecs[6]  = '{1'b1, 4, 4, 0};
        vecs[7]  = '{1'b1, 1, 5, 1};
        vecs[8]  = '{1'b1, 2, 6, 2};
        vecs[9]  = '{1'b1, 3, 7, 3};
        vecs[10] = '{1'b1, 4, 8, 0};

        rst = 1'b0;
        #2;
        check_all("async reset at start", 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c,
                 $sformatf("vec%0d", i));
            if (i == 2) check_ptrs_zero("reset hold");
        end

        // Continue to 20 edges total: five full laps of the default table.
        for (int k = 9; k <= 20; k++) begin
            step(1'b1, ((k - 1) % 4) + 1, ((k - 1) % 8) + 1, (((k - 1) % 8) + 1) % 4,
                 $sformatf("edge%0d", k));
        end

        // Edges 21..23 bring the default instance to 3.
        step(1'b1, 1, 5, 1, "edge21");
        step(1'b1, 2, 6, 2, "edge22");
        step(1'b1, 3, 7, 3, "edge23");

        // Asynchronous reset between edges clears outputs before the next edge.
        #2;
        rst = 1'b0;
        #1;
        check_all("async mid-stream", 0, 0, 0);
        check_ptrs_zero("async mid-stream");
        step(1'b0, 0, 0, 0, "reset held over edge");

        // Release between edges: stream restarts from entry 0.
        step(1'b1, 1, 1, 1, "restart 1");
        step(1'b1, 2, 2, 2, "restart 2");
        step(1'b1, 3, 3, 3, "restart 3");

        // Release coincident with a rising edge: that edge is not counted.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset before coincident release", 0, 0, 0);
        @(posedge clk);
        rst <= 1'b1;
        #1;
        check_all("coincident release edge", 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("after coincident release 1", 1, 1, 1);
        @(posedge clk);
        #1;
        check_all("after coincident release 2", 2, 2, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_buf_in.md
Name: stream_buf_in

Overview:
- Self-contained input-stream source buffer for the LDPC datapath.
- Holds a fixed table of 2^ADDR_WIDTH words in internal storage.
- Streams the table out one word per clock, in address order, wrapping forever.
- Feeds downstream decoder stages (and testbenches) with a deterministic, repeating data stream; no external load or handshake.

Parameters:
- DATA_WIDTH, 4, width in bits of each stored word and of data_out.
- ADDR_WIDTH, 2, width of the internal read pointer; table depth DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); clears state immediately regardless of clk.
- data_out  output  DATA_WIDTH  current stream word, registered.

Behaviour:
- Storage: DEPTH-entry array of DATA_WIDTH-bit words, read-only at run time.
- Contents fixed at elaboration: mem[i] = (i + 1) mod 2^DATA_WIDTH, for i = 0 .. DEPTH-1.
  - Default params: mem = {1, 2, 3, 4}.
  - Must not depend on reset.
- State: read pointer rd_addr (ADDR_WIDTH bits), output register data_out.
- Reset (rst == 0, asynchronous):
  - rd_addr = 0 and data_out = 0 immediately, without waiting for a clock edge.
  - Both held while rst stays 0; clock edges during reset are ignored.
- Normal operation (rst == 1), each rising clk edge:
  - data_out <= mem[rd_addr].
  - rd_addr <= rd_addr + 1, modulo DEPTH; natural ADDR_WIDTH-bit wrap, no separate compare.
- Latency:
  - First rising edge after rst goes 1: data_out = mem[0].
  - Edge k (k = 1, 2, ...): data_out = mem[(k-1) mod DEPTH].
- Wrap-around: after mem[DEPTH-1] the next edge outputs mem[0]; no gap or bubble cycle.
- Value wrap: if DEPTH > 2^DATA_WIDTH, stored values wrap modulo 2^DATA_WIDTH (e.g. DATA_WIDTH=2, ADDR_WIDTH=3 gives 1,2,3,0,1,2,3,0).
- Reset mid-stream: asserting rst at any point, including coincident with a clk edge, forces data_out = 0 and rd_addr = 0. After release the stream restarts from mem[0]; no resume from the old position.
- Reset deassertion coincident with a clk edge: that edge is not counted. The stream starts on the next edge.
- Outputs are never X after the first reset assertion. Power-up values before any reset are undefined.
- No combinational path from any input to data_out.

Test Plan:
- Reset hold: rst=0 for several clk edges -> data_out = 0 throughout; rd_addr = 0.
- Basic stream (defaults): release rst, clock 4 edges -> data_out = 1, 2, 3, 4 on successive edges.
- Wrap: continue 4 more edges -> 1, 2, 3, 4 repeated, no bubble; 20 edges give the 5-fold repeat.
- Async reset mid-stream: after data_out = 3, drive rst=0 between edges -> data_out = 0 immediately, before the next edge. Release -> next edges give 1, 2, 3...
- Parameter sweep: DATA_WIDTH=8, ADDR_WIDTH=3 -> 1..8 then wrap to 1. DATA_WIDTH=2, ADDR_WIDTH=3 -> 1,2,3,0,1,2,3,0.
- Reset released on clock edge: rst rises simultaneously with posedge -> data_out stays 0 for that edge; mem[0] appears on the following edge.
